// File: rtl/hdmi_async_fifo_lvl.sv
// hdmi_async_fifo_lvl: dual-clock gray-pointer FIFO carrying pixel words
// from i_clk to o_clk, with registered fill levels and almost flags.
// Optional sticky overflow flag: define HDMI_ASYNC_FIFO_OVF_EN.
module hdmi_async_fifo_lvl #(
    parameter int DW          = 8,
    parameter int EA          = 10,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = 768,
    parameter int AE_LEVEL    = 256
) (
    input  logic          i_rstn,
    input  logic          i_clk,
    input  logic          o_rstn,
    input  logic          o_clk,
    input  logic          i_tvalid,
    output logic          i_tready,
    input  logic [DW-1:0] i_tdata,
    output logic [EA:0]   w_level,
    output logic          w_almost_full,
`ifdef HDMI_ASYNC_FIFO_OVF_EN
    output logic          w_overflow,
`endif
    input  logic          o_tready,
    output logic          o_tvalid,
    output logic [DW-1:0] o_tdata,
    output logic [EA:0]   r_level,
    output logic          r_almost_empty
);

    localparam int          DEPTH = 1 << EA;
    localparam logic [EA:0] AF_TH = AF_LEVEL[EA:0];
    localparam logic [EA:0] AE_TH = AE_LEVEL[EA:0];

    function automatic logic [EA:0] bin2gray(input logic [EA:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [EA:0] gray2bin(input logic [EA:0] g);
        logic [EA:0] b;
        b[EA] = g[EA];
        for (int i = EA - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DW-1:0] mem [DEPTH];

    // write-domain state
    logic [EA:0]                  wptr;
    logic [EA:0]                  wgray;
    logic [EA:0]                  wptr_next;
    logic [SYNC_STAGES-1:0][EA:0] rgray_wsync;
    logic [EA:0]                  rgray_wq;
    logic [EA:0]                  rptr_wbin;
    logic [EA:0]                  w_level_next;
    logic                         full;
    logic                         wen;

    // read-domain state
    logic [EA:0]                  rptr;
    logic [EA:0]                  rgray;
    logic [EA:0]                  rptr_next;
    logic [SYNC_STAGES-1:0][EA:0] wgray_rsync;
    logic [EA:0]                  wptr_rbin;
    logic [EA:0]                  r_level_next;
    logic                         ren;

    // Full compares against the gray value that matches rptr_wbin, so
    // w_level can never read above DEPTH when a read frees a slot.
    assign full = (rgray_wq == {~wgray[EA:EA-1], wgray[EA-2:0]});
    assign i_tready = ~full;
    assign wen = i_tvalid & ~full;
    assign wptr_next = wptr + {{EA{1'b0}}, wen};
    assign w_level_next = wptr_next - rptr_wbin;

    // write pointer, read-pointer synchroniser, level and almost-full
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wptr          <= '0;
            wgray         <= '0;
            rgray_wsync   <= '0;
            rgray_wq      <= '0;
            rptr_wbin     <= '0;
            w_level       <= '0;
            w_almost_full <= 1'b0;
        end else begin
            wptr          <= wptr_next;
            wgray         <= bin2gray(wptr_next);
            rgray_wsync   <= {rgray_wsync[SYNC_STAGES-2:0], rgray};
            rgray_wq      <= rgray_wsync[SYNC_STAGES-1];
            rptr_wbin     <= gray2bin(rgray_wsync[SYNC_STAGES-1]);
            w_level       <= w_level_next;
            w_almost_full <= (w_level_next >= AF_TH);
        end
    end

    // storage write port
    always_ff @(posedge i_clk) begin
        if (wen) begin
            mem[wptr[EA-1:0]] <= i_tdata;
        end
    end

`ifdef HDMI_ASYNC_FIFO_OVF_EN
    // sticky flag: any write attempt while full, cleared only by reset
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            w_overflow <= 1'b0;
        end else if (i_tvalid && full) begin
            w_overflow <= 1'b1;
        end
    end
`endif

    assign ren = o_tvalid & o_tready;
    assign rptr_next = rptr + {{EA{1'b0}}, ren};
    assign r_level_next = wptr_rbin - rptr_next;

    // read pointer, write-pointer synchroniser, valid, level, almost-empty
    always_ff @(posedge o_clk or negedge o_rstn) begin
        if (!o_rstn) begin
            rptr           <= '0;
            rgray          <= '0;
            wgray_rsync    <= '0;
            wptr_rbin      <= '0;
            o_tvalid       <= 1'b0;
            r_level        <= '0;
            r_almost_empty <= 1'b0;
        end else begin
            rptr           <= rptr_next;
            rgray          <= bin2gray(rptr_next);
            wgray_rsync    <= {wgray_rsync[SYNC_STAGES-2:0], wgray};
            wptr_rbin      <= gray2bin(wgray_rsync[SYNC_STAGES-1]);
            o_tvalid       <= (wgray_rsync[SYNC_STAGES-1]
                               != bin2gray(rptr_next));
            r_level        <= r_level_next;
            r_almost_empty <= (r_level_next <= AE_TH);
        end
    end

    // first-word-fall-through output register; holds while not popped
    always_ff @(posedge o_clk) begin
        o_tdata <= mem[rptr_next[EA-1:0]];
    end

endmodule

// File: doc/hdmi_async_fifo_lvl.md
Name: hdmi_async_fifo_lvl

Overview:
Parametrised dual-clock FIFO that carries TMDS/pixel words from the user clock domain (i_clk) to the HDMI clock domain (o_clk). It extends the basic gray-pointer async FIFO in four ways:
- configurable synchroniser depth;
- registered fill-level outputs on both sides;
- programmable almost-full and almost-empty thresholds;
- an optional sticky overflow flag.
It sits between the user video source and the TMDS serialiser, and rate-control logic uses its levels.

Parameters:
DW, 8, data word width in bits
EA, 10, address width; depth = 2**EA words; legal range 2..14
SYNC_STAGES, 2, flip-flop stages in each pointer synchroniser; legal range 2..4
AF_LEVEL, 768, w_almost_full asserts when w_level >= AF_LEVEL; legal range 1..2**EA
AE_LEVEL, 256, r_almost_empty asserts when r_level <= AE_LEVEL; legal range 0..2**EA-1

Ports:
i_rstn  in  1  write-side reset; asynchronous, active-low
i_clk  in  1  write-side clock
o_rstn  in  1  read-side reset; asynchronous, active-low
o_clk  in  1  read-side clock
i_tvalid  in  1  write request
i_tready  out  1  FIFO not full (write side)
i_tdata  in  DW  write data
w_level  out  EA+1  write-side fill level, 0..2**EA
w_almost_full  out  1  w_level >= AF_LEVEL
w_overflow  out  1  sticky overflow flag; present only with the optional feature
o_tready  in  1  read accept
o_tvalid  out  1  o_tdata is valid
o_tdata  out  DW  read data, registered
r_level  out  EA+1  read-side fill level, 0..2**EA
r_almost_empty  out  1  r_level <= AE_LEVEL

Behaviour:
- Reset. Reset is i_rstn, asynchronous, active-low, on clock i_clk. o_rstn resets the read side in the same style.
  - i_rstn low: wptr, its gray register, the write-side synchroniser chain, w_level, w_almost_full and w_overflow all go to 0. i_tready goes to 1 in the first i_clk cycle after release.
  - o_rstn low: rptr, its gray register, the read-side synchroniser chain, o_tvalid, r_level and r_almost_empty all go to 0. r_almost_empty is 0 during reset and becomes 1 one o_clk after release (level 0 <= AE_LEVEL). o_tdata is not reset.
  - Both resets are overlapped by the system. Resetting one side alone mid-operation is unsupported. In that case levels may be wrong, but no X propagates and no lockup occurs once both sides have been reset.
- Pointers:
  - Binary pointers are EA+1 bits wide and wrap modulo 2**(EA+1).
  - Gray code is bin ^ (bin>>1), registered in the source domain before crossing.
  - Each crossing passes through SYNC_STAGES flops, then a registered gray-to-binary conversion.
- Write side:
  - A write is accepted when i_tvalid & i_tready. The word is stored at wptr[EA-1:0], then wptr increments.
  - full = (synced rptr gray == wptr gray with its top two bits inverted).
  - i_tready = ~full, combinational from registers.
- Read side: first-word-fall-through with registered output.
  - o_tdata <= mem[rptr_next]. rptr_next = rptr+1 when o_tvalid & o_tready, otherwise rptr.
  - o_tvalid <= (synced wptr gray != gray(rptr_next)).
  - o_tvalid and o_tdata hold stable while o_tready is 0.
- Latency: a word written at i_clk edge N is presented on o_tvalid no later than 1 i_clk + SYNC_STAGES+1 o_clk edges afterwards, plus up to 1 o_clk for edge alignment.
- Levels:
  - w_level <= wptr_next - synced_rptr_bin; it reflects the write accepted in the same cycle.
  - r_level <= synced_wptr_bin - rptr_next.
  - Both are unsigned EA+1-bit subtractions and never exceed 2**EA.
  - Both are pessimistic. w_level is never less than the true occupancy, and r_level is never more than it.
  - w_almost_full and r_almost_empty are registered in the same cycle as their levels.
- Boundaries:
  - Write when full: data is dropped, wptr holds, i_tready is already 0.
  - Read when empty: o_tvalid is 0 and rptr holds.
  - Simultaneous last read and new write: both complete; o_tvalid deasserts for at least the synchroniser latency.
  - Full-depth use: all 2**EA entries are usable, not 2**EA-1.

Optional Feature:
Macro HDMI_ASYNC_FIFO_OVF_EN.
- Defined: the w_overflow port exists. It is set on any i_clk edge with i_tvalid=1 and i_tready=0, and stays set until i_rstn asserts.
- Undefined: the port is omitted and no overflow logic is built.
- Accept/drop behaviour is identical in both builds.

Test Plan:
- Reset (DW=8, EA=4, AF=12, AE=4): both resets low then released. Expect i_tready=1, o_tvalid=0, w_level=0, r_level=0, r_almost_empty=1, w_overflow=0.
- Fill with o_tready=0: write 0x00..0x0F. Expect w_almost_full=1 from the cycle after the 12th accept, w_level=16, i_tready=0 after the 16th accept. A 17th attempt (0xAA) is not stored.
- Drain, i_clk 100 MHz / o_clk 74.25 MHz, o_tready=1: expect o_tdata sequence 0x00..0x0F, no gaps or duplicates. r_almost_empty returns to 1 once r_level <= 4. Finally o_tvalid=0 and r_level=0.
- Wrap-around: stream 100 incrementing words with random i_tvalid/o_tready throttling (50%). Expect all 100 received in order, w_level <= 16 throughout, and pointers wrap at least three times.
- Latency, SYNC_STAGES=3 on an empty FIFO: a single write of 0x5A. Expect o_tvalid within 5 o_clk edges after the write edge, with o_tdata=0x5A. o_tvalid and o_tdata stay stable while o_tready=0 for 10 cycles.
- Overflow, with HDMI_ASYNC_FIFO_OVF_EN: fill to 16, then assert i_tvalid one more cycle. Expect w_overflow=1 and sticky through a full drain; it clears only on i_rstn.
